dmem_responder: RTL and testbench

- Data-memory responder at the far end of the load/store path; the control decoder drives it with write enable and 3-bit width/sign control (funct3).
- Accepts one request per handshake, performs byte/half/word stores with lane masking, and returns sign- or zero-extended load data.
- Misaligned accesses that straddle two words are split into two internal word accesses by a small FSM.
- Storage is an internal word array with one access per cycle.

---
 rtl/dmem_responder_if.sv | 32 +++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module   : dmem_responder_if
// Purpose  : Request/response bundle between the load/store path and the
//            data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_width;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_width, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_width, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder. Byte/half/word loads and stores with lane
//            masking and sign/zero extension; accesses crossing a word
//            boundary are split into two word accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Access size in bytes from width[1:0] (the illegal code never reaches ACC)
  function automatic logic [2:0] size_of(input logic [1:0] w);
    case (w)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] w);
    case (w)
      2'b00:   lane_mask = 8'h01;
      2'b01:   lane_mask = 8'h03;
      default: lane_mask = 8'h0F;
    endcase
  endfunction

  // offset + size > 4 means the access touches the next word as well
  function automatic logic straddles(input logic [1:0] off, input logic [1:0] w);
    straddles = ({1'b0, off} + size_of(w)) > 3'd4;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_wr;
  logic              r_err;
  logic [AW+1:0]     r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_width;
  logic [31:0]       r_lo;
  logic [23:0]       r_hi;     // only the low three bytes of W+1 can ever be used
  logic [31:0]       mem [DEPTH_WORDS];

  logic              w_req_err;
  logic              w_straddle;
  logic [AW-1:0]     w_idx;
  logic [AW-1:0]     w_acc_idx;
  logic [31:0]       w_rd_word;
  logic [7:0]        w_be8;
  logic [63:0]       w_wd64;
  logic [3:0]        w_lane_be;
  logic [31:0]       w_lane_wd;
  logic              w_mem_we;
  logic [31:0]       w_sh;
  logic [31:0]       w_load_data;

  // A request is rejected up front if its width is illegal, it lies beyond
  // the array, or its second word would fall off the end (no wrap-around).
  assign w_req_err = (bus.req_width[1:0] == 2'b11)
                   || (|bus.req_addr[31:AW+2])
                   || (straddles(bus.req_addr[1:0], bus.req_width[1:0])
                       && (&bus.req_addr[AW+1:2]));

  assign w_straddle = straddles(r_addr[1:0], r_width[1:0]);
  assign w_idx      = r_addr[AW+1:2];
  assign w_acc_idx  = (r_state == ST_ACC2) ? (w_idx + AW'(1)) : w_idx;
  assign w_rd_word  = mem[w_acc_idx];

  // Store lanes over the 8-byte window {W+1, W}
  assign w_be8     = lane_mask(r_width[1:0]) << r_addr[1:0];
  assign w_wd64    = {32'h0, r_wdata} << {r_addr[1:0], 3'b000};
  assign w_lane_be = (r_state == ST_ACC2) ? w_be8[7:4]   : w_be8[3:0];
  assign w_lane_wd = (r_state == ST_ACC2) ? w_wd64[63:32] : w_wd64[31:0];
  assign w_mem_we  = r_wr && ((r_state == ST_ACC1) || (r_state == ST_ACC2));

  // Byte-lane writes into the word array; contents survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lane_be[b]) mem[w_acc_idx][8*b +: 8] <= w_lane_wd[8*b +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture the request fields on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_width <= '0;
    end else if ((r_state == ST_IDLE) && bus.req_valid) begin
      r_wr    <= bus.req_wr;
      r_err   <= w_req_err;
      r_addr  <= bus.req_addr[AW+1:0];
      r_wdata <= bus.req_wdata;
      r_width <= bus.req_width;
    end
  end

  // Latch the low word in ACC1 and the upper word in ACC2 for loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo <= '0;
      r_hi <= '0;
    end else if (!r_wr) begin
      if (r_state == ST_ACC1) r_lo <= w_rd_word;
      if (r_state == ST_ACC2) r_hi <= w_rd_word[23:0];
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.req_valid) w_state_nxt = w_req_err ? ST_RESP : ST_ACC1;
      ST_ACC1: w_state_nxt = w_straddle ? ST_ACC2 : ST_RESP;
      ST_ACC2: w_state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Align the loaded bytes to bit 0, then sign- or zero-extend
  always_comb begin
    w_sh = r_lo;
    case (r_addr[1:0])
      2'd1:    w_sh = {r_hi[7:0],  r_lo[31:8]};
      2'd2:    w_sh = {r_hi[15:0], r_lo[31:16]};
      2'd3:    w_sh = {r_hi[23:0], r_lo[31:24]};
      default: w_sh = r_lo;
    endcase
    case (r_width[1:0])
      2'b00:   w_load_data = r_width[2] ? {24'h0, w_sh[7:0]}
                                        : {{24{w_sh[7]}}, w_sh[7:0]};
      2'b01:   w_load_data = r_width[2] ? {16'h0, w_sh[15:0]}
                                        : {{16{w_sh[15]}}, w_sh[15:0]};
      default: w_load_data = w_sh;
    endcase
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_err   = (r_state == ST_RESP) && r_err;
  assign bus.rsp_rdata = ((r_state == ST_RESP) && !r_wr && !r_err) ? w_load_data : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder with a byte-level memory
//            model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int DW = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mb [0:DW*4-1];   // byte-addressed reference memory
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Build the expected response and update the reference memory
  function automatic exp_t model(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [2:0] wid);
    exp_t        e;
    int          size;
    int          off;
    bit          strad;
    logic [31:0] v;
    size  = (wid[1:0] == 2'b00) ? 1 : (wid[1:0] == 2'b01) ? 2 : 4;
    off   = int'(addr[1:0]);
    strad = (off + size) > 4;
    e.err = (wid[1:0] == 2'b11) || (addr >= 32'(DW*4))
          || (strad && ((addr >> 2) + 32'd1 == 32'(DW)));
    e.rdata = 32'h0;
    e.lat   = e.err ? 1 : (strad ? 3 : 2);
    if (!e.err) begin
      if (wr) begin
        for (int i = 0; i < size; i++) mb[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mb[int'(addr) + i];
        if (!wid[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!wid[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // One request through the DUT; hold>0 stalls the response with rsp_ready low
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] wid, input int hold);
    exp_t e;
    int   lat;
    bit   got;
    sb.push_back(model(wr, addr, wd, wid));
    @(negedge clk);
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_width = wid;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    got = 0;
    while (lat < 20 && !got) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) got = 1;
    end
    e = sb.pop_front();
    if (!got) begin
      check_eq("rsp_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("latency", 32'(lat), 32'(e.lat));
      check_eq("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      check_eq("rsp_rdata", bus.rsp_rdata, e.rdata);
      for (int k = 0; k < hold; k++) begin
        // a competing store while busy must be ignored
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0;
        bus.req_width = 3'b010;
        @(negedge clk);
        check_eq("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("hold_rsp_rdata", bus.rsp_rdata, e.rdata);
        check_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  // Word store interrupted by reset during ACC1 or ACC2. Interrupting ACC2
  // leaves W written and W+1 untouched; the model mirrors that.
  task automatic reset_mid(input logic [31:0] addr, input logic [31:0] wd, input bit in_acc2);
    int off;
    off = int'(addr[1:0]);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_width = 3'b010;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (in_acc2) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    if (in_acc2) begin
      for (int i = 0; i < 4; i++) if (off + i < 4) mb[int'(addr) + i] = wd[8*i +: 8];
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0] wsel [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_width = 3'b000;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("reset_rsp_err",   32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // aligned word
    do_req(1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
    do_req(0, 32'h10, 32'h0,        3'b010, 0);

    // byte sign/zero extension and lane isolation
    do_req(1, 32'h20, 32'h12345678, 3'b010, 0);
    do_req(1, 32'h21, 32'hFFFFFF80, 3'b000, 0);
    do_req(0, 32'h21, 32'h0, 3'b000, 0);
    do_req(0, 32'h21, 32'h0, 3'b100, 0);
    do_req(0, 32'h20, 32'h0, 3'b010, 0);

    // straddling half load
    do_req(1, 32'h30, 32'h11223344, 3'b010, 0);
    do_req(1, 32'h34, 32'h55667788, 3'b010, 0);
    do_req(0, 32'h33, 32'h0, 3'b001, 0);
    do_req(0, 32'h33, 32'h0, 3'b101, 0);

    // straddling word store
    do_req(1, 32'h40, 32'h01020304, 3'b010, 0);
    do_req(1, 32'h44, 32'h05060708, 3'b010, 0);
    do_req(1, 32'h42, 32'hAABBCCDD, 3'b010, 0);
    do_req(0, 32'h40, 32'h0, 3'b010, 0);
    do_req(0, 32'h44, 32'h0, 3'b010, 0);
    do_req(0, 32'h42, 32'h0, 3'b010, 0);

    // errors: illegal width, out of range, straddle past the last word
    do_req(1, 32'hFFC, 32'hCAFEF00D, 3'b010, 0);
    do_req(1, 32'h10, 32'h0, 3'b011, 0);
    do_req(0, 32'h10, 32'h0, 3'b011, 0);
    do_req(1, 32'h0000_1000, 32'h0, 3'b010, 0);
    do_req(1, 32'(DW*4 - 2), 32'h99999999, 3'b010, 0);
    do_req(0, 32'hFFF, 32'h0, 3'b001, 0);
    do_req(0, 32'hFFE, 32'h0, 3'b101, 0);
    do_req(0, 32'h10,  32'h0, 3'b010, 0);
    do_req(0, 32'hFFC, 32'h0, 3'b010, 0);

    // backpressure with an ignored request while busy
    do_req(0, 32'h30, 32'h0, 3'b010, 5);
    do_req(0, 32'h10, 32'h0, 3'b010, 0);

    // reset mid-operation
    reset_mid(32'h42, 32'h99887766, 1'b0);
    do_req(0, 32'h40, 32'h0, 3'b010, 0);
    do_req(0, 32'h44, 32'h0, 3'b010, 0);
    do_req(1, 32'h48, 32'hA1A2A3A4, 3'b010, 0);
    do_req(1, 32'h4C, 32'hB1B2B3B4, 3'b010, 0);
    reset_mid(32'h4A, 32'h11223344, 1'b1);
    do_req(0, 32'h48, 32'h0, 3'b010, 0);
    do_req(0, 32'h4C, 32'h0, 3'b010, 0);

    // random mix over a preloaded window
    for (int a = 32'h100; a < 32'h180; a += 4) do_req(1, 32'(a), $urandom, 3'b010, 0);
    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 123)),
             $urandom, wsel[$urandom_range(0, 4)], 0);
    end

    if (sb.size() != 0) check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
